// File: rtl/disp_pkg.sv
// Shared definitions for the temperature-readout digit sequencer.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TENS = 2'd1,
        ST_ONES = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'd10;
    localparam logic [5:0] LZ_LIMIT   = 6'd10;

    // Tens digit of a 0..63 reading (always 0..6).
    function automatic logic [3:0] tens_digit(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    // Ones digit of a 0..63 reading (always 0..9).
    function automatic logic [3:0] ones_digit(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

endpackage

// File: rtl/bin2dec.sv
// Shared binary-to-decimal converter: selects the tens or ones digit of a
// 6-bit value, or the blank code when neither select is active.
module bin2dec
    import disp_pkg::*;
(
    input  logic [5:0] bin,
    input  logic       sel_tens,
    input  logic       sel_ones,
    output logic [3:0] dec
);

    // Digit mux; tens select has priority, blank when idle.
    always_comb begin
        dec = BLANK_CODE;
        if (sel_tens) begin
            dec = tens_digit(bin);
        end else if (sel_ones) begin
            dec = ones_digit(bin);
        end
    end

endmodule

// File: rtl/disp_sequencer.sv
// Drives the single 7-segment digit: tens, ones, blank gap, each for DWELL
// cycles. New readings are queued in a one-deep pending register and only
// taken at a frame start, so a frame in flight never changes.
module disp_sequencer
    import disp_pkg::*;
#(
    parameter int DWELL       = 4,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_bin,
    input  logic       i_valid,
    input  logic       i_cont,
    output logic [3:0] o_dec,
    output logic       o_tens,
    output logic       o_ones,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int            CW       = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [5:0]    hold, hold_nx;
    logic [5:0]    pend, pend_nx;
    logic          pend_v, pend_v_nx;
    logic          pending;
    logic          last_cycle;
    logic          frame_start;
    logic          tens_nx, ones_nx, busy_nx, done_nx;

    // Next state, dwell count, hold/pend update and next registered outputs.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hold_nx     = hold;
        pend_nx     = pend;
        pend_v_nx   = pend_v;
        frame_start = 1'b0;
        last_cycle  = (cnt == CNT_LAST);
        // A strobe on this very edge counts as pending for the start decision.
        pending     = pend_v | i_valid;

        if (i_valid) begin
            pend_nx   = i_bin;
            pend_v_nx = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (pending) frame_start = 1'b1;
            end
            ST_TENS: begin
                if (last_cycle) begin
                    state_nx = ST_ONES;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_ONES: begin
                if (last_cycle) begin
                    state_nx = ST_GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (last_cycle) begin
                    if (i_cont || pending) begin
                        frame_start = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Frame start consumes the newest value; otherwise the old one repeats.
        if (frame_start) begin
            state_nx  = ST_TENS;
            cnt_nx    = '0;
            pend_v_nx = 1'b0;
            if (i_valid) begin
                hold_nx = i_bin;
            end else if (pend_v) begin
                hold_nx = pend;
            end
        end

        tens_nx = (state_nx == ST_TENS) &&
                  !((LZ_SUPPRESS != 0) && (hold_nx < LZ_LIMIT));
        ones_nx = (state_nx == ST_ONES);
        busy_nx = (state_nx != ST_IDLE);
        done_nx = (state_nx == ST_GAP) && (cnt_nx == CNT_LAST);
    end

    // State, data and output registers; reset clears everything at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            hold         <= '0;
            pend         <= '0;
            pend_v       <= 1'b0;
            o_tens       <= 1'b0;
            o_ones       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            hold         <= hold_nx;
            pend         <= pend_nx;
            pend_v       <= pend_v_nx;
            o_tens       <= tens_nx;
            o_ones       <= ones_nx;
            o_busy       <= busy_nx;
            o_frame_done <= done_nx;
        end
    end

    bin2dec u_bin2dec (
        .bin      (hold),
        .sel_tens (o_tens),
        .sel_ones (o_ones),
        .dec      (o_dec)
    );

endmodule

// File: tb/tb_disp_sequencer.sv
// Bench for disp_sequencer: three instances (DWELL=4 with and without
// leading-zero suppression, DWELL=1), table vectors, directed frame
// sequences, async reset, then random traffic against a frame-position model.
module tb_disp_sequencer;

    logic       clk;
    logic       rst;
    logic       valid [3];
    logic [5:0] bin   [3];
    logic       cont  [3];
    logic [3:0] dec   [3];
    logic       tens  [3];
    logic       ones  [3];
    logic       busy  [3];
    logic       done  [3];

    int checks = 0;
    int errors = 0;

    // Model state: frame position (-1 = idle, else 0..3*D-1), shown/pending value.
    int m_pos  [3];
    int m_hold [3];
    int m_pend [3];
    bit m_pv   [3];

    disp_sequencer #(.DWELL(4), .LZ_SUPPRESS(1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_bin(bin[0]), .i_valid(valid[0]),
        .i_cont(cont[0]), .o_dec(dec[0]), .o_tens(tens[0]), .o_ones(ones[0]),
        .o_busy(busy[0]), .o_frame_done(done[0]));

    disp_sequencer #(.DWELL(4), .LZ_SUPPRESS(0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_bin(bin[1]), .i_valid(valid[1]),
        .i_cont(cont[1]), .o_dec(dec[1]), .o_tens(tens[1]), .o_ones(ones[1]),
        .o_busy(busy[1]), .o_frame_done(done[1]));

    disp_sequencer #(.DWELL(1), .LZ_SUPPRESS(1)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_bin(bin[2]), .i_valid(valid[2]),
        .i_cont(cont[2]), .o_dec(dec[2]), .o_tens(tens[2]), .o_ones(ones[2]),
        .o_busy(busy[2]), .o_frame_done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int b;
        bit c;
        int e_dec;
        bit e_t;
        bit e_o;
        bit e_b;
        bit e_d;
    } vec_t;

    function automatic int dw(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit lz(input int k);
        return (k != 1);
    endfunction

    task automatic chk_out(input string nm, input int k, input int ed,
                           input bit et, input bit eo, input bit eb, input bit edn);
        checks++;
        if (dec[k] !== 4'(ed) || tens[k] !== et || ones[k] !== eo ||
            busy[k] !== eb || done[k] !== edn) begin
            errors++;
            $display("FAIL %s dut%0d got dec=%0d t=%0b o=%0b busy=%0b done=%0b want dec=%0d t=%0b o=%0b busy=%0b done=%0b",
                     nm, k, dec[k], tens[k], ones[k], busy[k], done[k], ed, et, eo, eb, edn);
        end
    endtask

    // Check the current cycle, apply this cycle's inputs, advance one clock.
    task automatic cyc(input string nm, input int k, input bit v, input int b, input bit c,
                       input int ed, input bit et, input bit eo, input bit eb, input bit edn);
        chk_out(nm, k, ed, et, eo, eb, edn);
        valid[k] = v;
        bin[k]   = 6'(b);
        cont[k]  = c;
        @(negedge clk);
    endtask

    // One complete frame with explicit digits (td=10 means suppressed tens);
    // optionally strobes vbin at frame offset vpos.
    task automatic check_frame(input string nm, input int k, input int d, input int td,
                               input int od, input bit c, input int vpos, input int vbin);
        for (int i = 0; i < 3 * d; i++) begin
            int ph;
            int e;
            ph = i / d;
            e  = (ph == 0) ? td : (ph == 1) ? od : 10;
            cyc(nm, k, (i == vpos), vbin, c, e, (ph == 0) && (td != 10), (ph == 1),
                1'b1, (i == 3 * d - 1));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pos[k]  = -1;
            m_hold[k] = 0;
            m_pend[k] = 0;
            m_pv[k]   = 1'b0;
        end
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step(input int k);
        int d;
        bit pending;
        bit start;
        d       = dw(k);
        pending = m_pv[k] || valid[k];
        start   = (m_pos[k] < 0 && pending) ||
                  (m_pos[k] == 3 * d - 1 && (cont[k] || pending));
        if (valid[k]) begin
            m_pend[k] = int'(bin[k]);
            m_pv[k]   = 1'b1;
        end
        if (start) begin
            if (m_pv[k]) m_hold[k] = m_pend[k];
            m_pv[k]  = 1'b0;
            m_pos[k] = 0;
        end else if (m_pos[k] >= 0) begin
            m_pos[k] = (m_pos[k] == 3 * d - 1) ? -1 : m_pos[k] + 1;
        end
    endtask

    task automatic model_check(input int k);
        int d;
        int ph;
        bit sup;
        int e;
        d   = dw(k);
        ph  = (m_pos[k] < 0) ? 3 : m_pos[k] / d;
        sup = lz(k) && (m_hold[k] < 10);
        e   = (ph == 0) ? (sup ? 10 : m_hold[k] / 10) :
              (ph == 1) ? (m_hold[k] % 10) : 10;
        chk_out("random", k, e, (ph == 0) && !sup, (ph == 1), (m_pos[k] >= 0),
                (m_pos[k] == 3 * d - 1));
    endtask

    vec_t vecs [14];

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            bin[k]   = '0;
            cont[k]  = 1'b0;
        end

        // Single-shot 42 on DWELL=4: 4x4, 2x4, blank x4, done on 12th, then idle.
        vecs[0] = '{1'b1, 42, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i <= 4; i++)  vecs[i] = '{1'b0, 0, 1'b0, 4,  1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 5; i <= 8; i++)  vecs[i] = '{1'b0, 0, 1'b0, 2,  1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 9; i <= 11; i++) vecs[i] = '{1'b0, 0, 1'b0, 10, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 0, 1'b0, 10, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0};

        #2;
        for (int k = 0; k < 3; k++) chk_out("reset_state", k, 10, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            cyc("table42", 0, vecs[i].v, vecs[i].b, vecs[i].c, vecs[i].e_dec,
                vecs[i].e_t, vecs[i].e_o, vecs[i].e_b, vecs[i].e_d);

        // Leading-zero suppression on values 7 and 0.
        cyc("lz7_start", 0, 1, 7, 0, 10, 0, 0, 0, 0);
        check_frame("lz7", 0, 4, 10, 7, 0, -1, 0);
        cyc("lz0_start", 0, 1, 0, 0, 10, 0, 0, 0, 0);
        check_frame("lz0", 0, 4, 10, 0, 0, -1, 0);

        // Strobe 63 on the frame_done cycle of a single-shot frame.
        cyc("s42_start", 0, 1, 42, 0, 10, 0, 0, 0, 0);
        check_frame("s42", 0, 4, 4, 2, 0, 11, 63);
        check_frame("s63_backtoback", 0, 4, 6, 3, 0, -1, 0);
        cyc("s63_idle", 0, 0, 0, 0, 10, 0, 0, 0, 0);

        // Continuous: 25 then 38 loaded mid-ONES; 38 repeats, then cont drops.
        cyc("c25_start", 0, 1, 25, 1, 10, 0, 0, 0, 0);
        check_frame("c25", 0, 4, 2, 5, 1, 5, 38);
        check_frame("c38a", 0, 4, 3, 8, 1, -1, 0);
        check_frame("c38b", 0, 4, 3, 8, 0, -1, 0);
        cyc("c_idle", 0, 0, 0, 0, 10, 0, 0, 0, 0);

        // No suppression: 7 shows 0 then 7.
        cyc("nolz7_start", 1, 1, 7, 0, 10, 0, 0, 0, 0);
        check_frame("nolz7", 1, 4, 0, 7, 0, -1, 0);
        cyc("nolz7_idle", 1, 0, 0, 0, 10, 0, 0, 0, 0);

        // DWELL=1 continuous: 3-cycle frames, done every third cycle.
        cyc("d1_start", 2, 1, 55, 1, 10, 0, 0, 0, 0);
        check_frame("d1a", 2, 1, 5, 5, 1, -1, 0);
        check_frame("d1b", 2, 1, 5, 5, 1, -1, 0);
        check_frame("d1c", 2, 1, 5, 5, 0, -1, 0);
        cyc("d1_idle", 2, 0, 0, 0, 10, 0, 0, 0, 0);

        // Asynchronous reset pulse between edges during ONES.
        cyc("ar_start", 0, 1, 42, 0, 10, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("ar_tens", 0, 0, 0, 0, 4, 1, 0, 1, 0);
        cyc("ar_ones", 0, 0, 0, 0, 2, 0, 1, 1, 0);
        #2 rst = 1'b1;
        #1 chk_out("async_reset", 0, 10, 0, 0, 0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) cyc("ar_stay_idle", 0, 0, 0, 0, 10, 0, 0, 0, 0);

        // Random traffic on all instances against the model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++) begin
                int sel;
                model_check(k);
                valid[k] = ($urandom_range(0, 5) == 0);
                sel = $urandom_range(0, 7);
                case (sel)
                    0: bin[k] = 6'd0;
                    1: bin[k] = 6'd9;
                    2: bin[k] = 6'd10;
                    3: bin[k] = 6'd63;
                    default: bin[k] = 6'($urandom_range(0, 63));
                endcase
                if ($urandom_range(0, 39) == 0) cont[k] = ~cont[k];
            end
            @(posedge clk);
            for (int k = 0; k < 3; k++) model_step(k);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_sequencer.md
# disp_sequencer

Sequences the shared binary-to-decimal converter that drives the single 7-segment digit of the temperature readout. It accepts a 6-bit reading (0..63) with a valid strobe and shows the tens digit, then the ones digit, then a blank gap, each for a programmable dwell time. It supports single-shot and continuous display modes. It sits between the sensor result register and the segment decoder, and is the only owner of the converter's digit-select inputs.

## Interface
- `DWELL`, default 4: cycles per phase (tens, ones, gap). Must be ≥ 1; 0 is illegal.
- `LZ_SUPPRESS`, default 1: when 1, the tens phase shows blank for values < 10.
- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_bin` in 6: reading to display. Sampled only when `i_valid`=1.
- `i_valid` in 1: one-cycle load strobe.
- `i_cont` in 1: 1 = repeat frames continuously, 0 = single-shot.
- `o_dec` in/out direction out, 4 bits: BCD digit to the segment decoder. Code 10 means blank.
- `o_tens` out 1: digit-select, tens. Registered.
- `o_ones` out 1: digit-select, ones. Registered.
- `o_busy` out 1: 1 while a frame is in progress.
- `o_frame_done` out 1: one-cycle pulse on the last gap cycle.

## Operation
- States and transitions:
  - IDLE, TENS, ONES, GAP.
  - IDLE→TENS when a pending value exists.
  - TENS→ONES→GAP after `DWELL` cycles in each.
  - GAP→TENS if (`i_cont` or pending), else GAP→IDLE.
- Registers:
  - `hold[5:0]`: value currently shown.
  - `pend[5:0]` + `pend_v`: latest strobed value.
  - dwell counter, width `$clog2(DWELL+1)`.
- `i_valid`: writes `pend` and sets `pend_v` in any state. The last strobe wins.
- Frame start (entry into TENS): `hold` ← `pend` if `pend_v`, and `pend_v` is cleared. Otherwise `hold` is kept, which is the continuous-repeat case.
- A frame in progress is never altered by new data.
- Selects by state:
  - TENS: `o_tens`=1, except when `LZ_SUPPRESS`=1 and `hold`<10, where both selects are 0.
  - ONES: `o_ones`=1.
  - IDLE/GAP: both 0.
- `o_dec` = converter output:
  - tens digit when `o_tens`=1;
  - ones digit when `o_ones`=1;
  - 10 otherwise.
- `o_busy` = 1 in TENS/ONES/GAP.
- `i_cont` dropped mid-frame: the frame completes, then IDLE unless `pend_v`.
- Valid bits of `i_bin`: all 6. 63 shows 6,3.

## Timing
- Reset values:
  - state IDLE; `hold`=0, `pend`=0, `pend_v`=0, counter 0;
  - `o_tens`=0, `o_ones`=0, `o_dec`=10, `o_busy`=0, `o_frame_done`=0.
- Latency:
  - `i_valid` sampled at edge t in IDLE → TENS output visible after edge t+1's register update (first display cycle = t+1).
  - Tens shows cycles t+1..t+DWELL, ones t+DWELL+1..t+2·DWELL, blank t+2·DWELL+1..t+3·DWELL.
- `o_frame_done` is high exactly on cycle t+3·DWELL. The next frame, if any, begins the following cycle with no idle gap.
- `i_valid` on the last GAP cycle: the value is captured and displayed in the immediately following frame, in either mode.
- `i_valid` on the same edge as the IDLE→TENS decision: the new value is used.
- Frame period is exactly 3·DWELL cycles. There is no jitter from leading-zero suppression.
- `i_reset` mid-frame: all state returns to reset values immediately (asynchronously). The pending value is lost.

## Structure
- Shared package `disp_pkg`:
  - state encoding (IDLE/TENS/ONES/GAP, 2 bits);
  - `BLANK_CODE`=4'd10;
  - `LZ_LIMIT`=6'd10.
- One sub-module: the existing `bin2dec` converter, instantiated once with `hold` on its binary input and the registered selects on its select inputs. `o_dec` is taken directly from it.
- Everything else (FSM, dwell counter, hold/pend registers) is in `disp_sequencer`.

## Test plan
- DWELL=4, `i_cont`=0, one `i_valid` with 42 → `o_dec` = 4×4, 2×4, 10×4. `o_frame_done` on the 12th cycle. Then IDLE with `o_busy`=0.
- LZ_SUPPRESS=1, value 7 → `o_dec` = 10×4, 7×4, 10×4. Value 0 → 10, 0, 10. With LZ_SUPPRESS=0, value 7 → 0, 7, 10.
- `i_cont`=1, load 25, then load 38 during the ONES phase → 2,5,blank finishes unchanged, then 3,8,blank. 38 then repeats with no idle cycle between frames.
- `i_valid` (value 63) on the `o_frame_done` cycle with `i_cont`=0 → the next cycle starts a frame showing 6, then 3.
- Async `i_reset` pulse mid-ONES (between edges) → outputs immediately 10/0/0/0. After release, stays IDLE until the next `i_valid`.
- DWELL=1 → frame of 3 cycles. `o_frame_done` is high every 3rd cycle in continuous mode.
